// File: rtl/network_source_pkg.sv
// Shared configuration for the network source stage: input count, source word width and FSM states.
package source_config;

    localparam int NET_NUM_INP = 8;
    localparam int SRC_WIDTH   = $clog2(NET_NUM_INP + 1);

    typedef enum logic [1:0] {
        COUNT,
        INDEX,
        SEND
    } src_state_t;

endpackage

// File: rtl/network_source.sv
// Turns a host word stream (count K, then K indices) into a one-hot spike vector for the network.
// Define NETWORK_SOURCE_ERR_EN to add a sticky err output for out-of-range indices and oversized counts.
module network_source
    import source_config::*;
#(
    parameter int NUM_INP   = NET_NUM_INP,
    parameter int SRC_WIDTH = $clog2(NUM_INP + 1)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [SRC_WIDTH-1:0] src,
    input  logic                 net_ready,
    output logic                 net_valid,
    output logic [NUM_INP-1:0]   net_inp
`ifdef NETWORK_SOURCE_ERR_EN
    ,
    output logic                 err
`endif
);

    // Handshake: a word or vector moves on a rising edge where its valid and ready are both high;
    // valid is held until that transfer happens.
    localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NUM_INP);

    src_state_t           state;
    logic [SRC_WIDTH-1:0] remaining;
    logic [NUM_INP-1:0]   hit;

    // Decoding by equality leaves out-of-range indices with no bit set.
    always_comb begin
        hit = '0;
        for (int j = 0; j < NUM_INP; j++) begin
            hit[j] = (src == SRC_WIDTH'(j));
        end
    end

    assign src_ready = (state != SEND) && !arst;
    assign net_valid = (state == SEND);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= COUNT;
            remaining <= '0;
            net_inp   <= '0;
        end else begin
            case (state)
                COUNT: begin
                    if (src_valid) begin
                        remaining <= src;
                        state     <= (src == '0) ? SEND : INDEX;
                    end
                end
                INDEX: begin
                    if (src_valid) begin
                        net_inp   <= net_inp | hit;
                        remaining <= remaining - SRC_WIDTH'(1);
                        if (remaining == SRC_WIDTH'(1)) begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (net_ready) begin
                        net_inp <= '0;
                        state   <= COUNT;
                    end
                end
                default: state <= COUNT;
            endcase
        end
    end

`ifdef NETWORK_SOURCE_ERR_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err <= 1'b0;
        end else if (src_valid) begin
            if ((state == COUNT && src > NUM_INP_W) ||
                (state == INDEX && src >= NUM_INP_W)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_network_source.sv
// Directed and randomized bench for network_source; expected vectors come from a frame-level model.
module tb_network_source;

  localparam int NUM_INP = 8;
  localparam int SW      = $clog2(NUM_INP + 1);

  logic               clk = 1'b0;
  logic               arst;
  logic               src_valid;
  logic               src_ready;
  logic [SW-1:0]      src;
  logic               net_ready;
  logic               net_valid;
  logic [NUM_INP-1:0] net_inp;
`ifdef NETWORK_SOURCE_ERR_EN
  logic               err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_seen = 0;
  int n_sent = 0;
  bit rand_mode = 1'b0;
  logic [NUM_INP-1:0] exp_q[$];

  network_source #(.NUM_INP(NUM_INP), .SRC_WIDTH(SW)) dut (
    .clk       (clk),
    .arst      (arst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src       (src),
    .net_ready (net_ready),
    .net_valid (net_valid),
    .net_inp   (net_inp)
`ifdef NETWORK_SOURCE_ERR_EN
    ,
    .err       (err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: the vector is the set of in-range indices of the frame.
  function automatic logic [NUM_INP-1:0] model_vec(input int idx[$]);
    logic [NUM_INP-1:0] v = '0;
    foreach (idx[i]) if (idx[i] < NUM_INP) v[idx[i]] = 1'b1;
    return v;
  endfunction

  // scoreboard: every accepted vector must match the oldest outstanding frame
  always @(negedge clk) begin
    if (!arst && net_valid && net_ready) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        chk("extra_vector", 32'(net_inp), 32'hDEAD);
      end else begin
        chk("vector", 32'(net_inp), 32'(exp_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) net_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input int w);
    int n = 0;
    src = SW'(w);
    src_valid = 1'b1;
    @(negedge clk);
    while (!src_ready && n < 60) begin
      step();
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("src_ready_timeout", 32'(n), 32'd0);
    step();
    src_valid = 1'b0;
  endtask

  task automatic send_frame(input int idx[$], input int max_gap);
    exp_q.push_back(model_vec(idx));
    n_sent++;
    send_word(idx.size());
    foreach (idx[i]) begin
      repeat ($urandom_range(0, max_gap)) step();
      send_word(idx[i]);
    end
  endtask

  task automatic send_raw(input int words[$]);
    foreach (words[i]) send_word(words[i]);
  endtask

  initial begin
    int idx[$];
    int k;
    int n;
    arst = 1'b1;
    src_valid = 1'b0;
    src = '0;
    net_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_net_valid", 32'(net_valid), 32'd0);
    chk("rst_net_inp", 32'(net_inp), 32'd0);
`ifdef NETWORK_SOURCE_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    step();
    arst = 1'b0;

    // K=0: empty vector one cycle after the count, source blocked until the net takes it
    send_raw('{0});
    @(negedge clk);
    chk("k0_valid", 32'(net_valid), 32'd1);
    chk("k0_inp", 32'(net_inp), 32'h00);
    chk("k0_src_ready", 32'(src_ready), 32'd0);
    step();
    @(negedge clk);
    chk("k0_src_ready_hold", 32'(src_ready), 32'd0);
    step();
    exp_q.push_back('0);
    n_sent++;
    net_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("k0_after_src_ready", 32'(src_ready), 32'd1);
    chk("k0_after_valid", 32'(net_valid), 32'd0);

    // 3,0,5,7 with net_ready high
    step();
    send_frame('{0, 5, 7}, 0);
    @(negedge clk);
    chk("a1_valid", 32'(net_valid), 32'd1);
    chk("a1_inp", 32'(net_inp), 32'hA1);
    chk("a1_src_ready", 32'(src_ready), 32'd0);
    step();
    @(negedge clk);
    chk("a1_valid_one_cycle", 32'(net_valid), 32'd0);
    chk("a1_src_ready_next", 32'(src_ready), 32'd1);
    step();

    // 2,4,4 under back-pressure
    net_ready = 1'b0;
    send_frame('{4, 4}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_inp", 32'(net_inp), 32'h10);
      chk("bp_valid", 32'(net_valid), 32'd1);
      chk("bp_src_ready", 32'(src_ready), 32'd0);
      step();
    end
    net_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_released", 32'(net_valid), 32'd0);
    step();

    // 2,9,1: out-of-range index consumed without setting a bit
    send_frame('{9, 1}, 0);
    @(negedge clk);
    chk("oor_inp", 32'(net_inp), 32'h02);
`ifdef NETWORK_SOURCE_ERR_EN
    chk("oor_err", 32'(err), 32'd1);
`endif
    step();
    @(negedge clk);
`ifdef NETWORK_SOURCE_ERR_EN
    chk("oor_err_sticky", 32'(err), 32'd1);
`endif
    step();

    // reset in the middle of a frame
    send_raw('{4, 1, 2});
    arst = 1'b1;
    @(negedge clk);
    chk("midrst_src_ready", 32'(src_ready), 32'd0);
    chk("midrst_inp", 32'(net_inp), 32'd0);
`ifdef NETWORK_SOURCE_ERR_EN
    chk("midrst_err", 32'(err), 32'd0);
`endif
    step();
    arst = 1'b0;
    send_frame('{6}, 0);
    @(negedge clk);
    chk("midrst_valid", 32'(net_valid), 32'd1);
    chk("midrst_new_inp", 32'(net_inp), 32'h40);
    step();

    // random frames with source gaps and random network back-pressure
    rand_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      idx.delete();
      k = $urandom_range(0, 10);
      for (int i = 0; i < k; i++) idx.push_back($urandom_range(0, 10));
      send_frame(idx, 2);
      repeat ($urandom_range(0, 1)) step();
    end
    rand_mode = 1'b0;
    net_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(n_seen), 32'(n_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
